load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage between the single-cycle core's datapath and data memory. Takes the ALU-computed address, rs2 store data, MemRW and funct3 of the current instruction. Drives a req/gnt/rvalid word-addressed memory port with byte enables, and returns sign- or zero-extended load data. Stalls the core (PC hold) while the access is outstanding.

## Interface
- ADDR_W, 32, byte-address width; data width is fixed at 32.
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- lsu_valid  in  1  current instruction is a load/store; held stable while stall=1
- MemRW  in  1  1=store, 0=load
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- addr  in  ADDR_W  byte address from the ALU
- wdata  in  32  store data (rs2)
- rdata  out  32  extended load data; valid when done=1
- done  out  1  one-cycle completion pulse
- fault  out  1  one-cycle pulse for a misaligned access or illegal funct3; coincides with done
- stall  out  1  core must hold PC/regfile write
- mem_req  out  1  memory request
- mem_we  out  1  write request
- mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  response (load data or store ack)
- mem_rdata  in  32  load word

## Operation
- FSM states: IDLE, REQ, RESP, DONE, ERR.
- IDLE, lsu_valid=1, legal and aligned: latch op, offset, be and wdata; go to REQ.
- IDLE, lsu_valid=1, illegal or misaligned: go to ERR; no memory request is issued.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0.
- Illegal funct3: 011, 110, 111, or any store with funct3[2]=1.
- REQ: mem_req=1; mem_addr, mem_we, mem_be and mem_wdata are registered and stable until mem_gnt. On mem_gnt, go to RESP.
- RESP: on mem_rvalid, capture the extended load value into rdata (stores set rdata=0); go to DONE.
- DONE: done=1; go to IDLE unconditionally. lsu_valid is ignored because it still refers to the completing instruction.
- ERR: done=1, fault=1, rdata=0; go to IDLE.
- Byte enables and store data:
  - SB: be = 4'b0001 << addr[1:0]; wdata = byte replicated ×4.
  - SH: be = 4'b0011 << {addr[1],1'b0}; wdata = half replicated ×2.
  - SW: be = 4'b1111; wdata unchanged.
- Load extract: field = mem_rdata >> (8·offset).
  - B/H are sign-extended from bit 7/15.
  - BU/HU are zero-extended.
- mem_be is 4'b1111 for all loads.
- stall = (IDLE & lsu_valid) | REQ | RESP. It is combinational and low in DONE and ERR.

## Timing
- Reset values: state IDLE; mem_req, mem_we, done, fault = 0; mem_addr, mem_be, mem_wdata, rdata = 0. stall follows lsu_valid in IDLE.
- Best case (gnt in first REQ cycle, rvalid the next cycle):
  - T0: IDLE sees lsu_valid.
  - T1: REQ, gnt arrives.
  - T2: RESP, rvalid arrives.
  - T3: DONE.
  - Net: 4 cycles per access, 3 stall cycles.
- Fault path: T0 IDLE, T1 ERR. That is 2 cycles, 1 stall cycle.
- Each gnt wait cycle adds 1 cycle; each rvalid wait cycle adds 1 cycle.
- mem_rvalid outside RESP is ignored, including rvalid coincident with gnt in REQ and late responses after reset.
- mem_gnt outside REQ is ignored.
- Reset mid-operation: next cycle IDLE with all outputs at reset values; mem_req drops even with a grant pending.
- Back-to-back memory instructions: next op is sampled in IDLE the cycle after DONE.

## Structure
- Package lsu_pkg holds:
  - localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the lsu_state_t enum {IDLE, REQ, RESP, DONE, ERR}.
- Combinational sub-module load_extender (inputs: word, offset, funct3; output: 32-bit result) is instantiated once for the RESP capture.
- Byte-enable/store-lane generation stays inline.

## Test plan
- LW addr 0x100, gnt immediately, rvalid next cycle with 0xDEADBEEF -> mem_addr 0x100, be 1111, done at T3, rdata 0xDEADBEEF, stall high T0–T2.
- LB addr 0x103, mem_rdata 0x80FF_0000 -> rdata 0xFFFFFF80; LBU same stimulus -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
- SB addr 0x201, wdata 0x000000AB, gnt delayed 3 cycles -> mem_addr 0x200, be 0010, mem_wdata 0xABABABAB stable all 4 REQ cycles, mem_we=1.
- LW addr 0x102 -> ERR next cycle: done=fault=1, mem_req never asserted, rdata 0. Store with funct3 100 -> same response.
- Reset asserted in RESP, then rvalid arrives -> IDLE, done never pulses, outputs at reset values, stray rvalid ignored.
- Two loads back to back, the second presented the cycle after DONE -> second mem_req at DONE+2, no dropped or duplicated request.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        DONE,
        ERR
    } lsu_state_t;

endpackage

// File: rtl/load_extender.sv
// Selects the addressed byte/half of a load word and sign/zero extends it.
module load_extender
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        result  = shifted;
        unique case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   result = {24'h0, shifted[7:0]};
            F3_HU:   result = {16'h0, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: req/gnt/rvalid word port with byte lanes,
// load extension, and a PC stall while the access is outstanding.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lsu_valid,
    input  logic              MemRW,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              fault,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t  state;
    logic        store_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        illegal;
    logic        misaligned;
    logic [3:0]  be_c;
    logic [31:0] wd_c;
    logic [31:0] ext;

    always_comb begin
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                  (funct3 == 3'b111) || (MemRW && funct3[2]);
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        be_c = 4'b1111;
        wd_c = wdata;
        // Stores place the datum on every lane; be picks the live one.
        if (MemRW) begin
            unique case (funct3[1:0])
                2'b00: begin
                    be_c = 4'b0001 << addr[1:0];
                    wd_c = {4{wdata[7:0]}};
                end
                2'b01: begin
                    be_c = 4'b0011 << {addr[1], 1'b0};
                    wd_c = {2{wdata[15:0]}};
                end
                default: begin
                    be_c = 4'b1111;
                    wd_c = wdata;
                end
            endcase
        end
    end

    load_extender u_ext (
        .word   (mem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .result (ext)
    );

    assign stall = ((state == IDLE) && lsu_valid) ||
                   (state == REQ) || (state == RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
            rdata     <= 32'h0;
            done      <= 1'b0;
            fault     <= 1'b0;
            store_q   <= 1'b0;
            off_q     <= 2'b00;
            f3_q      <= 3'b000;
        end else begin
            unique case (state)
                IDLE: begin
                    if (lsu_valid) begin
                        if (illegal || misaligned) begin
                            state <= ERR;
                            done  <= 1'b1;
                            fault <= 1'b1;
                            rdata <= 32'h0;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= MemRW;
                            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            mem_be    <= be_c;
                            mem_wdata <= wd_c;
                            store_q   <= MemRW;
                            off_q     <= addr[1:0];
                            f3_q      <= funct3;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (mem_rvalid) begin
                        rdata <= store_q ? 32'h0 : ext;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                ERR: begin
                    done  <= 1'b0;
                    fault <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_valid;
    logic        MemRW;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        fault;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int req_cyc  = 0;
    int hs_cnt   = 0;
    int done_cnt = 0;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .lsu_valid  (lsu_valid),
        .MemRW      (MemRW),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .done       (done),
        .fault      (fault),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req) req_cyc++;
        if (mem_req && mem_gnt) hs_cnt++;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic we,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rword,
                          input int gwait, input int rwait,
                          input logic early_rv, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic [31:0] erd);
        lsu_valid = 1'b1;
        MemRW     = we;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        #1;
        check({tag, ".stall_t0"}, 32'(stall), 32'd1);
        tick();
        for (int i = 0; i <= gwait; i++) begin
            check({tag, ".req"}, 32'(mem_req), 32'd1);
            check({tag, ".we"}, 32'(mem_we), 32'(we));
            check({tag, ".maddr"}, mem_addr, {a[31:2], 2'b00});
            check({tag, ".be"}, 32'(mem_be), 32'(ebe));
            if (we) check({tag, ".mwdata"}, mem_wdata, ewd);
            check({tag, ".stall_req"}, 32'(stall), 32'd1);
            if (i == gwait) begin
                mem_gnt    = 1'b1;
                mem_rvalid = early_rv;
                mem_rdata  = 32'hBAD0_BAD0;
            end
            tick();
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        for (int i = 0; i <= rwait; i++) begin
            check({tag, ".req_resp"}, 32'(mem_req), 32'd0);
            check({tag, ".done_resp"}, 32'(done), 32'd0);
            check({tag, ".stall_resp"}, 32'(stall), 32'd1);
            if (i == rwait) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rword;
            end
            tick();
        end
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".fault"}, 32'(fault), 32'd0);
        check({tag, ".rdata"}, rdata, erd);
        check({tag, ".stall_done"}, 32'(stall), 32'd0);
        lsu_valid = 1'b0;
        tick();
        check({tag, ".done_clr"}, 32'(done), 32'd0);
        check({tag, ".req_idle"}, 32'(mem_req), 32'd0);
    endtask

    task automatic run_fault(input string tag, input logic we,
                             input logic [2:0] f3, input logic [31:0] a);
        int rc;
        rc        = req_cyc;
        lsu_valid = 1'b1;
        MemRW     = we;
        funct3    = f3;
        addr      = a;
        wdata     = 32'h5555_5555;
        #1;
        check({tag, ".stall_t0"}, 32'(stall), 32'd1);
        tick();
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".fault"}, 32'(fault), 32'd1);
        check({tag, ".rdata"}, rdata, 32'h0);
        check({tag, ".req"}, 32'(mem_req), 32'd0);
        check({tag, ".stall_err"}, 32'(stall), 32'd0);
        lsu_valid = 1'b0;
        tick();
        check({tag, ".done_clr"}, 32'(done), 32'd0);
        check({tag, ".fault_clr"}, 32'(fault), 32'd0);
        check({tag, ".no_req"}, 32'(req_cyc - rc), 32'd0);
    endtask

    initial begin
        int hs0;
        int dc0;
        reset      = 1'b1;
        lsu_valid  = 1'b0;
        MemRW      = 1'b0;
        funct3     = 3'b010;
        addr       = 32'h0;
        wdata      = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        check("rst.req", 32'(mem_req), 32'd0);
        check("rst.we", 32'(mem_we), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.fault", 32'(fault), 32'd0);
        check("rst.rdata", rdata, 32'h0);
        check("rst.maddr", mem_addr, 32'h0);
        check("rst.be", 32'(mem_be), 32'h0);
        check("rst.mwdata", mem_wdata, 32'h0);
        check("rst.stall", 32'(stall), 32'd0);

        run_op("lw", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF,
               0, 0, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF);
        run_op("lb", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000,
               0, 0, 1'b0, 4'hF, 32'h0, 32'hFFFF_FF80);
        run_op("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000,
               0, 0, 1'b0, 4'hF, 32'h0, 32'h0000_0080);
        run_op("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF_0000,
               0, 0, 1'b0, 4'hF, 32'h0, 32'h0000_80FF);
        run_op("lh", 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_0000,
               1, 2, 1'b0, 4'hF, 32'h0, 32'hFFFF_80FF);
        run_op("lb2", 1'b0, 3'b000, 32'h102, 32'h0, 32'h80FF_0000,
               0, 0, 1'b0, 4'hF, 32'h0, 32'hFFFF_FFFF);
        run_op("sb", 1'b1, 3'b000, 32'h201, 32'h0000_00AB, 32'h0,
               3, 0, 1'b0, 4'b0010, 32'hABAB_ABAB, 32'h0);
        run_op("sh", 1'b1, 3'b001, 32'h202, 32'h0000_1234, 32'h0,
               0, 1, 1'b0, 4'b1100, 32'h1234_1234, 32'h0);
        run_op("sw", 1'b1, 3'b010, 32'h204, 32'hCAFE_F00D, 32'h0,
               0, 0, 1'b0, 4'hF, 32'hCAFE_F00D, 32'h0);

        run_op("lw_pre", 1'b0, 3'b010, 32'h300, 32'h0, 32'h1122_3344,
               0, 0, 1'b0, 4'hF, 32'h0, 32'h1122_3344);
        run_fault("lw_mis", 1'b0, 3'b010, 32'h102);
        run_fault("st_f3", 1'b1, 3'b100, 32'h100);
        run_fault("lh_mis", 1'b0, 3'b001, 32'h101);
        run_fault("ld_ill", 1'b0, 3'b011, 32'h100);

        // Reset while a load waits in RESP; a stray rvalid follows.
        run_op("lw_rst0", 1'b0, 3'b010, 32'h400, 32'h0, 32'h7777_7777,
               0, 0, 1'b0, 4'hF, 32'h0, 32'h7777_7777);
        dc0       = done_cnt;
        lsu_valid = 1'b1;
        MemRW     = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h100;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt   = 1'b0;
        lsu_valid = 1'b0;
        reset     = 1'b1;
        tick();
        reset      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        check("rst_mid.req", 32'(mem_req), 32'd0);
        check("rst_mid.done", 32'(done), 32'd0);
        check("rst_mid.rdata", rdata, 32'h0);
        check("rst_mid.maddr", mem_addr, 32'h0);
        check("rst_mid.be", 32'(mem_be), 32'h0);
        check("rst_mid.stall", 32'(stall), 32'd0);
        tick();
        mem_rvalid = 1'b0;
        tick();
        check("rst_mid.no_done", 32'(done_cnt - dc0), 32'd0);
        check("rst_mid.rdata2", rdata, 32'h0);
        check("rst_mid.stall2", 32'(stall), 32'd0);

        // Reset in REQ with a grant pending drops mem_req.
        lsu_valid = 1'b1;
        tick();
        mem_gnt   = 1'b1;
        reset     = 1'b1;
        lsu_valid = 1'b0;
        tick();
        reset = 1'b0;
        check("rst_req.req", 32'(mem_req), 32'd0);
        mem_gnt = 1'b0;
        tick();

        hs0 = hs_cnt;
        run_op("b2b_a", 1'b0, 3'b010, 32'h500, 32'h0, 32'hAAAA_0001,
               0, 0, 1'b0, 4'hF, 32'h0, 32'hAAAA_0001);
        run_op("b2b_b", 1'b0, 3'b010, 32'h504, 32'h0, 32'hAAAA_0002,
               0, 0, 1'b1, 4'hF, 32'h0, 32'hAAAA_0002);
        check("b2b.handshakes", 32'(hs_cnt - hs0), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
